// File: rtl/sprite_fill_engine_if.sv
// Sprite-memory write port: the engine drives words, the memory side
// answers with wr_ready when it takes the presented word.
interface sprite_fill_engine_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr_ready;

    modport master (
        output we, addr, data,
        input  wr_ready
    );

    modport slave (
        input  we, addr, data,
        output wr_ready
    );
endinterface

// File: rtl/sprite_fill_engine.sv
// Fills NUM_BLOCKS square sprites with palette colours, optionally with
// a border ring, one word per accepted write.
module sprite_fill_engine #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int SPRITE_W   = 24,
    parameter int NUM_BLOCKS = 9,
    parameter int BASE_ADDR  = 0,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         border_mode,
    input  logic [NUM_BLOCKS*DATA_W-1:0] palette,
    input  logic [DATA_W-1:0]            border_color,
    sprite_fill_engine_if.master         wr,
    output logic                         dis,
    output logic                         done
);

    localparam int BLOCK_WORDS = SPRITE_W * SPRITE_W;
    localparam int KW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int SW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam logic [KW-1:0]     K_LAST = KW'(NUM_BLOCKS - 1);
    localparam logic [SW-1:0]     S_LAST = SW'(SPRITE_W - 1);
    localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(BASE_ADDR);

    if (longint'(BASE_ADDR) + longint'(NUM_BLOCKS) * longint'(BLOCK_WORDS)
        > (longint'(1) << ADDR_W)) begin : g_size_err
        $error("sprite_fill_engine: sprites do not fit in address space");
    end

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q;
    logic              we_q, dis_q, done_q, bmode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [KW-1:0]     k_q;
    logic [SW-1:0]     row_q, col_q;

    logic [KW-1:0]     k_n;
    logic [SW-1:0]     row_n, col_n;
    logic              last, ring;
    logic [DATA_W-1:0] pix_n;

    // Power-of-two table so any k index stays in range.
    logic [DATA_W-1:0] pal [0:(1<<KW)-1];

    for (genvar i = 0; i < (1 << KW); i++) begin : g_pal
        if (i < NUM_BLOCKS) begin : g_used
            assign pal[i] = palette[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign pal[i] = '0;
        end
    end

    // Counters and pixel colour for the word that follows the current one.
    always_comb begin
        col_n = col_q + SW'(1);
        row_n = row_q;
        k_n   = k_q;
        last  = 1'b0;
        if (col_q == S_LAST) begin
            col_n = '0;
            row_n = row_q + SW'(1);
            if (row_q == S_LAST) begin
                row_n = '0;
                k_n   = k_q + KW'(1);
                last  = (k_q == K_LAST);
            end
        end
        ring  = (row_n == '0) || (row_n == S_LAST) ||
                (col_n == '0) || (col_n == S_LAST);
        pix_n = (bmode_q && ring) ? border_color : pal[k_n];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= AUTO_START ? FILL : IDLE;
            dis_q   <= AUTO_START;
            we_q    <= 1'b0;
            addr_q  <= A_BASE;
            data_q  <= '0;
            done_q  <= 1'b0;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            bmode_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FILL;
                        dis_q   <= 1'b1;
                        bmode_q <= border_mode;
                        we_q    <= 1'b1;
                        addr_q  <= A_BASE;
                        data_q  <= border_mode ? border_color : pal[0];
                    end
                end
                FILL: begin
                    // we is low here only right after reset: word 0 is a corner.
                    if (!we_q) begin
                        we_q   <= 1'b1;
                        data_q <= bmode_q ? border_color : pal[0];
                    end else if (wr.wr_ready) begin
                        if (last) begin
                            state_q <= IDLE;
                            we_q    <= 1'b0;
                            dis_q   <= 1'b0;
                            done_q  <= 1'b1;
                            addr_q  <= A_BASE;
                            k_q     <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            k_q    <= k_n;
                            row_q  <= row_n;
                            col_q  <= col_n;
                            data_q <= pix_n;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr.we   = we_q;
    assign wr.addr = addr_q;
    assign wr.data = data_q;
    assign dis     = dis_q;
    assign done    = done_q;

endmodule

// File: doc/sprite_fill_engine.md
# sprite_fill_engine

Parametrised sprite-RAM fill engine, the successor to the fixed nine-colour sprite initializer. After reset, or on a `start` pulse, it writes NUM_BLOCKS square sprites of SPRITE_W×SPRITE_W pixels into sprite memory. Each sprite is filled with its palette colour; in border mode the outer pixel ring is drawn in a separate border colour. The write port has a ready handshake so the engine can sit behind a memory arbiter. `dis` holds the display off while a fill is in progress.

## Interface

- ADDR_W, 13, sprite-memory address width
- DATA_W, 8, pixel width (RGB332 at default)
- SPRITE_W, 24, sprite edge in pixels; BLOCK_WORDS = SPRITE_W*SPRITE_W
- NUM_BLOCKS, 9, number of sprites filled
- BASE_ADDR, 0, address of pixel 0 of sprite 0
- AUTO_START, 1, fill starts automatically after reset release
- Constraint: BASE_ADDR + NUM_BLOCKS*BLOCK_WORDS <= 2^ADDR_W (elaboration-time check)

Ports:

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to re-run the fill; honoured only in IDLE
- border_mode  in  1  sampled when a fill begins; 1 = draw a border ring
- palette  in  NUM_BLOCKS*DATA_W  colour of sprite k is palette[k*DATA_W +: DATA_W]; must be static during a fill
- border_color  in  DATA_W  ring colour; must be static during a fill
- wr_ready  in  1  memory accepts the presented word this cycle
- we  out  1  write request
- addr  out  ADDR_W  write address
- data  out  DATA_W  write data
- dis  out  1  1 = display disabled (fill pending or in progress)
- done  out  1  one-cycle pulse after the last word is accepted

## Operation

- States: IDLE, FILL.
- Reset values (asynchronous, while rst=0): state=FILL if AUTO_START else IDLE; dis=AUTO_START; we=0; addr=BASE_ADDR; data=0; done=0; block, row and col counters=0; latched border_mode=0.
- FILL: present the word for counters (k,row,col) with we=1.
  - addr = BASE_ADDR + k*BLOCK_WORDS + row*SPRITE_W + col, computed by an incrementing ADDR_W counter, not a multiplier.
  - data = border_color if the latched border_mode=1 and (row==0 or row==SPRITE_W-1 or col==0 or col==SPRITE_W-1); otherwise palette[k].
  - Word accepted on a rising edge with we=1 and wr_ready=1. On acceptance, col increments. col wraps at SPRITE_W-1 and carries into row; row wraps at SPRITE_W-1 and carries into k.
  - Acceptance of the final word (k=NUM_BLOCKS-1, row=col=SPRITE_W-1) goes to IDLE: we=0, dis=0, done=1 for one cycle. Counters and addr return to 0 / BASE_ADDR.
- IDLE: we=0, dis=0.
  - start=1 goes to FILL, sets dis=1, and latches border_mode.
- start during FILL is ignored. border_mode changes during FILL have no effect.
- rst asserted mid-fill: all outputs return to reset values immediately. After release the fill restarts from word 0 (AUTO_START=1) or the engine idles.

## Timing

- First word is presented at the first rising edge after rst deasserts (AUTO_START=1), or at the edge that samples start=1: that edge sets we=1, addr=BASE_ADDR and the word-0 data.
- Throughput is one word per cycle while wr_ready=1. Total FILL length is NUM_BLOCKS*BLOCK_WORDS cycles plus stall cycles.
- Stall: with we=1 and wr_ready=0, addr and data hold unchanged and we stays 1. wr_ready has no effect while we=0.
- done and the dis fall occur at the same edge that accepts the last word. we is 0 from that edge onward.
- A start sampled at the same edge that accepts the last word is ignored (the engine is still in FILL). start in the following cycle is honoured.
- All outputs are registered; none depend combinationally on inputs.

## Test plan

- Defaults, wr_ready=1, border_mode=0, palette {FF,1C,E0,03,EC,FC,E3,1F,00} for k=0..8, rst released → we high for exactly 5184 cycles. addr 0..5183. data=FF for addr 0–575, 1C for 576–1151, …, 00 for 4608–5183. done pulses once; dis=0 from then on.
- border_mode=1, border_color=00, same palette → addr 0–23 data=00; addr 24=00; addr 25=FF; addr 47=00; addr 575=00; addr 601 (sprite 1, row 1, col 1)=1C.
- wr_ready toggled 1,0,0,1 repeating → addr and data stable across every stall. Each address is written exactly once. Total we-high cycles = 5184 plus the stall count.
- rst pulsed low at addr 2000 → we=0, addr=0, dis=1 immediately. After release the fill restarts at addr 0 and completes all 5184 words.
- start pulsed in IDLE with border_mode=1, then border_mode driven to 0 mid-fill; also start pulsed mid-fill → a single full bordered fill; the mid-fill start has no effect.
- SPRITE_W=4, NUM_BLOCKS=2, BASE_ADDR=100, AUTO_START=0 → no writes until start. Then addr 100..131, done at the acceptance of addr 131.
